board_io_frontend: RTL

Board-side end of the memory-mapped GPIO interface. It produces the 14-bit `io_input_bus` read by the CPU's IO read path:
- raw slide switches and push-buttons are synchronised, inverted to logical active-high and debounced.
- `io_input_bus[9:0]` carries the switches; `io_input_bus[13:10]` carries keys 0..3.

It also consumes the 52-bit `io_output_bus` written by the CPU:
- `io_output_bus[9:0]` drives the red LEDs.
- `io_output_bus[51:10]` drives six 7-bit HEX displays.

It sits between top-level board pins and the data memory.

---
 rtl/board_io_pkg.sv | 15 +
 rtl/board_io_if.sv | 12 +
 rtl/board_io_frontend_debounce.sv | 44 ++++
 rtl/board_io_frontend.sv | 76 +++++++
 4 files changed

// File: rtl/board_io_pkg.sv
// Shared widths and field offsets for the board-side GPIO frontend.
// Imported by the CPU-bus interface and the frontend RTL.
package board_io_pkg;

    localparam int SW_W     = 10;
    localparam int KEY_W    = 4;
    localparam int HEX_W    = 7;
    localparam int NUM_HEX  = 6;
    localparam int IO_IN_W  = 14;
    localparam int IO_OUT_W = 52;

    localparam int LED_LSB  = 0;
    localparam int HEX_LSB  = 10;

endpackage

// File: rtl/board_io_if.sv
// CPU-facing memory-mapped GPIO buses: switch/key read word and LED/HEX write word.
// The frontend is the slave; the data-memory IO path is the master.
interface board_io_if;
    import board_io_pkg::*;

    logic [IO_IN_W-1:0]  io_input_bus;
    logic [IO_OUT_W-1:0] io_output_bus;

    modport slave  (output io_input_bus, input  io_output_bus);
    modport master (input  io_input_bus, output io_output_bus);

endinterface

// File: rtl/board_io_frontend_debounce.sv
// One input-conditioning channel: 2-flop synchroniser followed by a
// counter-based debouncer whose stable register is the channel output.
module debounce_channel #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clock,
    input  logic reset_n,
    input  logic raw,
    output logic level
);

    localparam int             CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_p0;
    logic             sync_p1;
    logic             stable_p2;
    logic [CNT_W-1:0] cnt_p2;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            sync_p0   <= 1'b0;
            sync_p1   <= 1'b0;
            stable_p2 <= 1'b0;
            cnt_p2    <= '0;
        end else begin
            // stage p0/p1: metastability filter on the asynchronous pin
            sync_p0 <= raw;
            sync_p1 <= sync_p0;
            // stage p2: any return to the stable level restarts the count
            if (sync_p1 == stable_p2) begin
                cnt_p2 <= '0;
            end else if (cnt_p2 == CNT_LAST) begin
                stable_p2 <= sync_p1;
                cnt_p2    <= '0;
            end else begin
                cnt_p2 <= cnt_p2 + CNT_W'(1);
            end
        end
    end

    assign level = stable_p2;

endmodule

// File: rtl/board_io_frontend.sv
// Board-side GPIO frontend: debounced switches/keys onto the CPU read bus,
// registered LED and raw seven-segment patterns from the CPU write bus.
module board_io_frontend
    import board_io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter bit KEY_ACTIVE_LOW  = 1'b1,
    parameter bit HEX_ACTIVE_LOW  = 1'b1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [SW_W-1:0]  sw_in,
    input  logic [KEY_W-1:0] key_in,
    board_io_if.slave        cpu,
    output logic [SW_W-1:0]  ledr,
    output logic [HEX_W-1:0] hex0,
    output logic [HEX_W-1:0] hex1,
    output logic [HEX_W-1:0] hex2,
    output logic [HEX_W-1:0] hex3,
    output logic [HEX_W-1:0] hex4,
    output logic [HEX_W-1:0] hex5
);

    localparam logic [HEX_W-1:0] HEX_DARK = HEX_ACTIVE_LOW ? {HEX_W{1'b1}} : {HEX_W{1'b0}};

    function automatic logic [HEX_W-1:0] seg_drive(input logic [HEX_W-1:0] pattern);
        return HEX_ACTIVE_LOW ? ~pattern : pattern;
    endfunction

    logic [KEY_W-1:0]   key_logical;
    logic [IO_IN_W-1:0] raw_bits;
    logic [IO_IN_W-1:0] level_bits;

    assign key_logical = key_in ^ {KEY_W{KEY_ACTIVE_LOW}};
    assign raw_bits    = {key_logical, sw_in};

    for (genvar ch = 0; ch < IO_IN_W; ch++) begin : g_chan
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_chan (
            .clock   (clock),
            .reset_n (reset_n),
            .raw     (raw_bits[ch]),
            .level   (level_bits[ch])
        );
    end

    assign cpu.io_input_bus = level_bits;

    logic [SW_W-1:0]  ledr_p0;
    logic [HEX_W-1:0] hex_p0 [NUM_HEX];

    // stage p0: single register between CPU write word and board pins
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            ledr_p0 <= '0;
            for (int i = 0; i < NUM_HEX; i++) begin
                hex_p0[i] <= HEX_DARK;
            end
        end else begin
            ledr_p0 <= cpu.io_output_bus[LED_LSB +: SW_W];
            for (int i = 0; i < NUM_HEX; i++) begin
                hex_p0[i] <= seg_drive(cpu.io_output_bus[HEX_LSB + i*HEX_W +: HEX_W]);
            end
        end
    end

    assign ledr = ledr_p0;
    assign hex0 = hex_p0[0];
    assign hex1 = hex_p0[1];
    assign hex2 = hex_p0[2];
    assign hex3 = hex_p0[3];
    assign hex4 = hex_p0[4];
    assign hex5 = hex_p0[5];

endmodule
